bcd_convert_arbiter: RTL and testbench
======================================

# bcd_convert_arbiter

Shared, sequential binary-to-BCD conversion engine serving two requesters (e.g. score path and timer path) that both feed the 8-digit seven-segment display. Replaces per-requester combinational divide/modulo chains with one iterative double-dabble datapath. A round-robin arbiter grants the engine, runs a 32-step shift-add-3 conversion and returns eight packed BCD digits with a one-cycle completion pulse tagged by requester ID.

## Interface
- WIDTH, 32, binary operand width; also the number of shift steps.
- DIGITS, 8, BCD digits returned; output width 4*DIGITS.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0  in  1  requester 0 conversion request; hold high with bin0 stable until done with done_id=0.
- bin0  in  WIDTH  requester 0 unsigned binary operand.
- req1  in  1  requester 1 conversion request; same rules as req0.
- bin1  in  WIDTH  requester 1 unsigned binary operand.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse: bcd_out and done_id valid.
- done_id  out  1  requester that owns the completed result.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0], digit 7 in [31:28]; held until next done.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if any req high, grant and load; grant = requester not equal to last_grant when both high, else the single requester. Operand copied into binary shift register, BCD accumulator (4*(DIGITS+2)=40 bits) cleared, step counter cleared, last_grant updated, go SHIFT. No req: stay.
- SHIFT: per cycle, every 4-bit accumulator digit >= 5 gets +3, then {accumulator, binary} shifted left 1. After WIDTH steps go DONE.
- DONE: bcd_out <= low 4*DIGITS bits of accumulator; done <= 1; done_id <= grant; go IDLE.
- Result equals operand mod 10^DIGITS; digits 8 and 9 of the accumulator are discarded, never saturated.
- Operand sampled only at grant; later changes to binN are ignored.
- Requester dropping req mid-conversion: conversion completes, done still pulses with its ID; result left for anyone.
- Requester holding req after its done: treated as a new request at next IDLE sample (subject to round-robin).
- Reset (any state): state IDLE, busy 0, done 0, done_id 0, bcd_out 0, last_grant 1 (so req0 wins first tie), in-flight conversion abandoned with no done.

## Timing
- Edge E0: req sampled in IDLE, operand loaded.
- Edges E1..E32: shift steps; state DONE after E32.
- Edge E33: done=1, bcd_out/done_id updated, state IDLE; done falls at E34.
- Earliest next grant at E34; back-to-back period 34 cycles.
- busy high from after E0 through E33; low after E33.
- Latency request-sample to done: 33 cycles; worst-case wait with other requester queued: 67 cycles.
- No combinational path from req/bin inputs to any output.

## Test plan
- Reset then req0, bin0=0 -> done at E33, done_id=0, bcd_out=0x00000000; busy low after.
- req0 with bin0=12345678 -> bcd_out=0x12345678; bin0=99999999 -> 0x99999999.
- Wrap: bin1=100000000 -> bcd_out=0x00000000; bin1=0xFFFFFFFF -> 0x94967295, done_id=1.
- Tie after reset: req0=req1=1 held, bin0=42, bin1=7 -> done_id=0 bcd_out=0x00000042 at E33, then done_id=1 bcd_out=0x00000007 at E67; continued holding alternates 0,1,0.
- Operand change mid-conversion: bin0=555 at E0, changed to 999 at E5 -> result 0x00000555.
- Reset at E15 of a conversion -> no done pulse, bcd_out=0, busy=0; next req0 tie-breaks to requester 0.

Source files
------------

// File: rtl/bcd_convert_arbiter.sv
// Shared binary-to-BCD engine: round-robin grant between two requesters, 32-step double-dabble, 33 cycles grant-to-done.
// Requesters hold req and operand until their done; the loser of a tie waits for the next IDLE sample.
module bcd_convert_arbiter #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic [WIDTH-1:0]      bin0,
   input  logic                  req1,
   input  logic [WIDTH-1:0]      bin1,
   output logic                  busy,
   output logic                  done,
   output logic                  done_id,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int ACCW = 4 * (DIGITS + 2);
   localparam int CNTW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state, state_nxt;
   logic [ACCW-1:0]   acc, acc_adj;
   logic [WIDTH-1:0]  bin_sr;
   logic [CNTW-1:0]   step;
   logic              grant, last_grant, grant_nxt;
   logic              load, last_step;

   // On a tie the requester that did not win last time gets the engine.
   assign grant_nxt = (req0 && req1) ? ~last_grant : req1;
   assign last_step = (step == CNTW'(WIDTH - 1));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE:    if (req0 || req1) begin
                     load      = 1'b1;
                     state_nxt = SHIFT;
                  end
         SHIFT:   if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      acc_adj = acc;
      for (int d = 0; d < DIGITS + 2; d++) begin
         if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc        <= '0;
         bin_sr     <= '0;
         step       <= '0;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         done       <= 1'b0;
         done_id    <= 1'b0;
         bcd_out    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (load) begin
                     bin_sr     <= grant_nxt ? bin1 : bin0;
                     acc        <= '0;
                     step       <= '0;
                     grant      <= grant_nxt;
                     last_grant <= grant_nxt;
                  end
            SHIFT: begin
                     acc    <= {acc_adj[ACCW-2:0], bin_sr[WIDTH-1]};
                     bin_sr <= bin_sr << 1;
                     step   <= step + CNTW'(1);
                  end
            // Digits above DIGITS-1 are dropped so the result wraps mod 10^DIGITS.
            DONE: begin
                     bcd_out <= acc[4*DIGITS-1:0];
                     done    <= 1'b1;
                     done_id <= grant;
                  end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for bcd_convert_arbiter: vector table for single conversions plus tie, operand-change, drop and reset sequences.
module tb_bcd_convert_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [31:0] bin0, bin1;
   logic        busy, done, done_id;
   logic [31:0] bcd_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   bcd_convert_arbiter #(.WIDTH(32), .DIGITS(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .bin0    (bin0),
      .req1    (req1),
      .bin1    (bin1),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .bcd_out (bcd_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r0;
      logic        r1;
      logic [31:0] b0;
      logic [31:0] b1;
      logic        eid;
      logic [31:0] ebcd;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Counts edges until done is seen (first edge after call = 1); bounded.
   task automatic wait_done(input string name, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!done && cyc < 200);
      total_cnt++;
      if (done) pass_cnt++;
      else $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
   endtask

   int cyc;
   int seen;

   initial begin
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;

      vt[0] = '{1'b1, 1'b0, 32'd0,          32'd0,          1'b0, 32'h00000000};
      vt[1] = '{1'b1, 1'b0, 32'd12345678,   32'd0,          1'b0, 32'h12345678};
      vt[2] = '{1'b1, 1'b0, 32'd99999999,   32'd0,          1'b0, 32'h99999999};
      vt[3] = '{1'b0, 1'b1, 32'd0,          32'd100000000,  1'b1, 32'h00000000};
      vt[4] = '{1'b0, 1'b1, 32'd0,          32'hFFFFFFFF,   1'b1, 32'h94967295};
      vt[5] = '{1'b0, 1'b1, 32'd0,          32'd1234567890, 1'b1, 32'h34567890};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_done_id", 32'(done_id), 32'd0);
      chk("reset_bcd", bcd_out, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         req0 = vt[i].r0; req1 = vt[i].r1; bin0 = vt[i].b0; bin1 = vt[i].b1;
         wait_done($sformatf("vec%0d", i), cyc);
         req0 = 1'b0; req1 = 1'b0;
         chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'd34);
         chk($sformatf("vec%0d_id", i), 32'(done_id), 32'(vt[i].eid));
         chk($sformatf("vec%0d_bcd", i), bcd_out, vt[i].ebcd);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
         chk($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
         chk($sformatf("vec%0d_bcd_held", i), bcd_out, vt[i].ebcd);
      end

      // Tie after reset: requester 0 first, then alternate while both hold.
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1; bin0 = 32'd42; bin1 = 32'd7;
      wait_done("tie0", cyc);
      chk("tie0_latency", 32'(cyc), 32'd34);
      chk("tie0_id", 32'(done_id), 32'd0);
      chk("tie0_bcd", bcd_out, 32'h00000042);
      wait_done("tie1", cyc);
      chk("tie1_period", 32'(cyc), 32'd34);
      chk("tie1_id", 32'(done_id), 32'd1);
      chk("tie1_bcd", bcd_out, 32'h00000007);
      wait_done("tie2", cyc);
      req0 = 1'b0; req1 = 1'b0;
      chk("tie2_id", 32'(done_id), 32'd0);
      chk("tie2_bcd", bcd_out, 32'h00000042);
      @(posedge clk); #1;

      // Operand changed after grant is ignored.
      req0 = 1'b1; bin0 = 32'd555;
      repeat (5) @(posedge clk);
      #1;
      bin0 = 32'd999;
      chk("opchg_busy_mid", 32'(busy), 32'd1);
      wait_done("opchg", cyc);
      req0 = 1'b0;
      chk("opchg_bcd", bcd_out, 32'h00000555);
      chk("opchg_id", 32'(done_id), 32'd0);
      @(posedge clk); #1;

      // Request dropped mid-conversion still completes with its ID.
      req1 = 1'b1; bin1 = 32'd2024;
      repeat (10) @(posedge clk);
      #1;
      req1 = 1'b0;
      wait_done("drop", cyc);
      chk("drop_id", 32'(done_id), 32'd1);
      chk("drop_bcd", bcd_out, 32'h00002024);
      @(posedge clk); #1;

      // Reset mid-conversion abandons it without a done pulse.
      req0 = 1'b1; bin0 = 32'd31337;
      repeat (15) @(posedge clk);
      #1;
      req0 = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_bcd", bcd_out, 32'd0);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("midrst_no_done", 32'(seen), 32'd0);
      req0 = 1'b1; req1 = 1'b1; bin0 = 32'd11; bin1 = 32'd22;
      wait_done("midrst_tie", cyc);
      req0 = 1'b0; req1 = 1'b0;
      chk("midrst_tie_id", 32'(done_id), 32'd0);
      chk("midrst_tie_bcd", bcd_out, 32'h00000011);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
